// File: rtl/if_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
// Imported by if_stage and if_hold_buf.
package if_stage_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry buffer holding a fetched instruction and its pc
// while the decode stage is stalled.
module if_hold_buf
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] data_in,
    input  logic [31:0] pc_in,
    output logic [31:0] data,
    output logic [31:0] pc,
    output logic        valid
);

    // clear wins over load; load captures the pair and marks it valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= IF_NOP_INST;
            pc    <= 32'd0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single outstanding imem request,
// redirect/stall handling and the IF/ID pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o
);

    if_state_t   state, state_nx;
    logic [31:0] fetch_pc, fetch_pc_nx;
    logic [31:0] out_pc, out_pc_nx;
    logic        discard, discard_nx;
    logic        req;
    logic [31:0] addr;
    logic        ifid_we, ifid_vld;
    logic [31:0] ifid_inst, ifid_pc;
    logic        buf_load, buf_clear, buf_valid;
    logic [31:0] buf_data, buf_pc;

    if_hold_buf u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (buf_load),
        .clear   (buf_clear),
        .data_in (imem_rdata_i),
        .pc_in   (out_pc),
        .data    (buf_data),
        .pc      (buf_pc),
        .valid   (buf_valid)
    );

    // next-state, request and IF/ID write selection
    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        out_pc_nx   = out_pc;
        discard_nx  = discard;
        req         = 1'b0;
        ifid_vld    = 1'b0;
        ifid_inst   = NOP_INST;
        ifid_pc     = 32'd0;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        addr        = br_taken_i ? br_target_i : fetch_pc;
        addr[1:0]   = 2'b00;
        // redirect overrides stall; otherwise a stall freezes IF/ID
        ifid_we     = br_taken_i || !stall_i;
        unique case (state)
            S_REQ: begin
                req = br_taken_i || !stall_i;
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_nx = S_REQ;
                    if (discard) begin
                        discard_nx = 1'b0;
                    end else if (br_taken_i) begin
                        req = 1'b1;
                    end else if (stall_i) begin
                        buf_load = 1'b1;
                        state_nx = S_HOLD;
                    end else begin
                        req       = 1'b1;
                        ifid_vld  = 1'b1;
                        ifid_inst = imem_rdata_i;
                        ifid_pc   = out_pc;
                    end
                end else if (br_taken_i) begin
                    discard_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (br_taken_i) begin
                    buf_clear = 1'b1;
                    state_nx  = S_REQ;
                end else if (!stall_i) begin
                    buf_clear = 1'b1;
                    ifid_vld  = buf_valid;
                    ifid_inst = buf_valid ? buf_data : NOP_INST;
                    ifid_pc   = buf_valid ? buf_pc : 32'd0;
                    state_nx  = S_REQ;
                end
            end
            default: begin
                state_nx = S_REQ;
            end
        endcase
        if (req && imem_ready_i) begin
            out_pc_nx   = addr;
            fetch_pc_nx = addr + 32'd4;
            state_nx    = S_WAIT;
        end else if (br_taken_i) begin
            fetch_pc_nx = br_target_i;
        end
    end

    assign imem_req_o  = req && rst_n;
    assign imem_addr_o = addr;

    // state, fetch progress and the IF/ID register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            out_pc   <= 32'd0;
            discard  <= 1'b0;
            inst_o   <= NOP_INST;
            pc_o     <= 32'd0;
            pc4_o    <= 32'd0;
        end else begin
            state    <= state_nx;
            fetch_pc <= fetch_pc_nx;
            out_pc   <= out_pc_nx;
            discard  <= discard_nx;
            if (ifid_we) begin
                inst_o <= ifid_inst;
                pc_o   <= ifid_pc;
                pc4_o  <= ifid_vld ? ifid_pc + 32'd4 : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a transaction-level model
// checked every cycle plus literal expectations.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic        req;
    logic [31:0] addr;
    logic        ready = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [31:0] inst, pc, pc4;

    int total = 0;
    int bad = 0;

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .br_taken_i    (br),
        .br_target_i   (tgt),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ready_i  (ready),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .inst_o        (inst),
        .pc_o          (pc),
        .pc4_o         (pc4)
    );

    always #5 clk = ~clk;

    // Model: one outstanding transaction, an optional parked
    // instruction, the next sequential fetch address and IF/ID.
    logic        m_pend, m_squash, m_buf_v;
    logic [31:0] m_pend_pc, m_buf_inst, m_buf_pc, m_next;
    logic [31:0] m_inst, m_pc, m_pc4;
    logic        m_req;
    logic [31:0] m_addr;

    always_comb begin
        m_addr = br ? tgt : m_next;
        if (!rst_n || m_buf_v)
            m_req = 1'b0;
        else if (!m_pend)
            m_req = br || !stall;
        else
            m_req = rvalid && !m_squash && (br || !stall);
    end

    always @(posedge clk or negedge rst_n) begin
        logic resp, good, acc;
        if (!rst_n) begin
            m_pend = 0; m_squash = 0; m_buf_v = 0;
            m_pend_pc = 0; m_buf_inst = 0; m_buf_pc = 0;
            m_next = 0; m_inst = NOP; m_pc = 0; m_pc4 = 0;
        end else begin
            resp = m_pend && rvalid;
            good = resp && !m_squash;
            acc  = m_req && ready;
            if (br) begin
                m_inst = NOP; m_pc = 0; m_pc4 = 0;
            end else if (!stall) begin
                if (m_buf_v) begin
                    m_inst = m_buf_inst; m_pc = m_buf_pc;
                    m_pc4 = m_buf_pc + 4;
                end else if (good) begin
                    m_inst = rdata; m_pc = m_pend_pc;
                    m_pc4 = m_pend_pc + 4;
                end else begin
                    m_inst = NOP; m_pc = 0; m_pc4 = 0;
                end
            end
            if (br || !stall) m_buf_v = 0;
            else if (good) begin
                m_buf_v = 1; m_buf_inst = rdata; m_buf_pc = m_pend_pc;
            end
            if (acc) begin
                m_pend = 1; m_pend_pc = m_addr; m_squash = 0;
            end else if (resp) m_pend = 0;
            else if (br && m_pend) m_squash = 1;
            if (acc) m_next = m_addr + 4;
            else if (br) m_next = tgt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("m_req", {31'd0, req}, {31'd0, m_req});
        if (m_req) chk("m_addr", addr, m_addr);
        chk("m_inst", inst, m_inst);
        chk("m_pc", pc, m_pc);
        chk("m_pc4", pc4, m_pc4);
    end

    task automatic drive(input logic s, input logic b,
                         input logic [31:0] t, input logic rdy,
                         input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        stall = s; br = b; tgt = t;
        ready = rdy; rvalid = rv; rdata = rd;
    endtask

    task automatic win;
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (3) drive(0, 0, 0, 1, 0, 0);
        win();
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc4", pc4, 32'd0);
        drive(0, 0, 0, 1, 0, 0);
        rst_n = 1'b1;
        win();
        chk("a_addr", addr, 32'h0);
        chk("a_req", {31'd0, req}, 32'd1);
        drive(0, 0, 0, 1, 1, 32'h0050_0093);
        win();
        chk("b_addr", addr, 32'h4);
        drive(0, 0, 0, 1, 1, 32'h0010_0113);
        win();
        chk("c_inst", inst, 32'h0050_0093);
        chk("c_pc", pc, 32'h0);
        chk("c_pc4", pc4, 32'h4);
        chk("c_addr", addr, 32'h8);
        drive(1, 0, 0, 1, 1, 32'h00A0_0113);
        win();
        chk("d_req", {31'd0, req}, 32'd0);
        drive(1, 0, 0, 1, 0, 0);
        win();
        chk("e_inst", inst, 32'h0010_0113);
        drive(1, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        win();
        chk("g_req", {31'd0, req}, 32'd0);
        chk("g_inst", inst, 32'h0010_0113);
        drive(0, 0, 0, 0, 0, 0);
        win();
        chk("h_inst", inst, 32'h00A0_0113);
        chk("h_pc", pc, 32'h8);
        chk("h_pc4", pc4, 32'hC);
        chk("h_addr", addr, 32'hC);
        drive(0, 0, 0, 0, 0, 0);
        win();
        chk("i_inst", inst, NOP);
        chk("i_pc", pc, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        win();
        chk("k_req", {31'd0, req}, 32'd1);
        chk("k_addr", addr, 32'hC);
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 1, 32'h100, 1, 0, 0);
        win();
        chk("m_req0", {31'd0, req}, 32'd0);
        drive(0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        win();
        chk("n_inst", inst, NOP);
        chk("n_req", {31'd0, req}, 32'd0);
        drive(0, 0, 0, 1, 0, 0);
        win();
        chk("o_addr", addr, 32'h100);
        chk("o_inst", inst, NOP);
        drive(1, 0, 0, 1, 1, 32'h1111_1111);
        drive(1, 1, 32'h100, 1, 0, 0);
        win();
        chk("q_req", {31'd0, req}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        win();
        chk("r_inst", inst, NOP);
        chk("r_addr", addr, 32'h100);
        drive(0, 1, 32'hFFFF_FFFC, 1, 0, 0);
        win();
        chk("s_addr", addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, 1, 32'h0000_0293);
        win();
        chk("t_addr", addr, 32'h0);
        drive(0, 0, 0, 1, 1, 32'h0040_0313);
        win();
        chk("u_inst", inst, 32'h0000_0293);
        chk("u_pc", pc, 32'hFFFF_FFFC);
        chk("u_pc4", pc4, 32'h0);
        chk("u_addr", addr, 32'h4);
        drive(0, 0, 0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        win();
        chk("v_req", {31'd0, req}, 32'd0);
        chk("v_inst", inst, NOP);
        drive(0, 0, 0, 1, 1, 32'h0BAD_0BAD);
        drive(0, 0, 0, 1, 1, 32'hBAD0_BAD0);
        rst_n = 1'b1;
        win();
        chk("w_addr", addr, 32'h0);
        chk("w_req", {31'd0, req}, 32'd1);
        drive(0, 0, 0, 1, 0, 0);
        win();
        chk("x_inst", inst, NOP);
        repeat (3) drive(0, 0, 0, 1, 0, 0);
        win();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
